// File: rtl/pulse_gen.sv
// rtl/pulse_gen.sv - periodic pulse generator with shadowed period/width config
// A valid offer lands in the shadow slot and is promoted at idle or at a period boundary.
module pulse_gen #(
  parameter int T_CNT_WIDTH = 32,
  parameter int PCNT_WIDTH  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic [T_CNT_WIDTH-1:0] period_i,
  input  logic [T_CNT_WIDTH-1:0] width_i,
  input  logic                   cfg_vld_i,
  output logic                   cfg_rdy_o,
  input  logic                   oe_i,
  output logic                   sig_o,
  output logic                   stb_o,
  output logic                   run_o,
  output logic                   err_o,
  output logic [PCNT_WIDTH-1:0]  pulse_cnt_o
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t                 r_state;
  logic [T_CNT_WIDTH-1:0] r_act_period;
  logic [T_CNT_WIDTH-1:0] r_act_width;
  logic                   r_act_vld;
  logic [T_CNT_WIDTH-1:0] r_sh_period;
  logic [T_CNT_WIDTH-1:0] r_sh_width;
  logic                   r_sh_pend;
  logic [T_CNT_WIDTH-1:0] r_cnt;
  logic                   r_level;
  logic                   r_stb;
  logic                   r_err;
  logic [PCNT_WIDTH-1:0]  r_pcnt;

  logic                   w_xfer;
  logic                   w_cfg_ok;
  logic [T_CNT_WIDTH-1:0] w_low_len;
  logic                   w_low_done;
  logic                   w_apply;

  assign w_xfer     = cfg_vld_i & ~r_sh_pend;
  assign w_cfg_ok   = (period_i >= T_CNT_WIDTH'(2)) && (width_i >= T_CNT_WIDTH'(1)) &&
                      (width_i < period_i);
  assign w_low_len  = r_act_period - r_act_width;
  assign w_low_done = (r_state == LOW) && (r_cnt == w_low_len);
  // Promotion needs a pending shadow, so it never coincides with a new transfer.
  assign w_apply    = r_sh_pend && ((r_state == IDLE) || w_low_done);

  assign cfg_rdy_o   = ~r_sh_pend;
  assign sig_o       = r_level & oe_i;
  assign stb_o       = r_stb;
  assign run_o       = (r_state != IDLE);
  assign err_o       = r_err;
  assign pulse_cnt_o = r_pcnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_act_period <= '0;
      r_act_width  <= '0;
      r_act_vld    <= 1'b0;
      r_sh_period  <= '0;
      r_sh_width   <= '0;
      r_sh_pend    <= 1'b0;
      r_cnt        <= '0;
      r_level      <= 1'b0;
      r_stb        <= 1'b0;
      r_err        <= 1'b0;
      r_pcnt       <= '0;
    end else begin
      r_stb <= 1'b0;

      if (w_xfer) begin
        if (w_cfg_ok) begin
          r_sh_period <= period_i;
          r_sh_width  <= width_i;
          r_sh_pend   <= 1'b1;
          r_err       <= 1'b0;
        end else begin
          r_err <= 1'b1;
        end
      end

      if (w_apply) begin
        r_act_period <= r_sh_period;
        r_act_width  <= r_sh_width;
        r_act_vld    <= 1'b1;
        r_sh_pend    <= 1'b0;
      end

      // r_cnt holds the 1-based index of the current cycle within HIGH or LOW.
      case (r_state)
        IDLE: begin
          if (en_i && r_act_vld) begin
            r_state <= HIGH;
            r_level <= 1'b1;
            r_stb   <= 1'b1;
            r_cnt   <= T_CNT_WIDTH'(1);
            r_pcnt  <= r_pcnt + PCNT_WIDTH'(1);
          end
        end
        HIGH: begin
          if (r_cnt == r_act_width) begin
            r_state <= LOW;
            r_level <= 1'b0;
            r_cnt   <= T_CNT_WIDTH'(1);
          end else begin
            r_cnt <= r_cnt + T_CNT_WIDTH'(1);
          end
        end
        LOW: begin
          if (w_low_done) begin
            if (en_i) begin
              r_state <= HIGH;
              r_level <= 1'b1;
              r_stb   <= 1'b1;
              r_cnt   <= T_CNT_WIDTH'(1);
              r_pcnt  <= r_pcnt + PCNT_WIDTH'(1);
            end else begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + T_CNT_WIDTH'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_gen.sv
// tb/tb_pulse_gen.sv - self-checking bench for pulse_gen
// Table vectors feed a per-cycle scoreboard; hand sequences cover reload, error, enable and reset corners.
module tb_pulse_gen;

  localparam int TW = 12;
  localparam int PW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          en_i;
  logic [TW-1:0] period_i;
  logic [TW-1:0] width_i;
  logic          cfg_vld_i;
  logic          cfg_rdy_o;
  logic          oe_i;
  logic          sig_o;
  logic          stb_o;
  logic          run_o;
  logic          err_o;
  logic [PW-1:0] pulse_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  pulse_gen #(.T_CNT_WIDTH(TW), .PCNT_WIDTH(PW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .period_i    (period_i),
    .width_i     (width_i),
    .cfg_vld_i   (cfg_vld_i),
    .cfg_rdy_o   (cfg_rdy_o),
    .oe_i        (oe_i),
    .sig_o       (sig_o),
    .stb_o       (stb_o),
    .run_o       (run_o),
    .err_o       (err_o),
    .pulse_cnt_o (pulse_cnt_o)
  );

  typedef struct {int period; int width; int nper; int exp_hi; int exp_lo;} vec_t;
  typedef struct {logic sig; logic stb; logic run; logic [PW-1:0] pcnt;} exp_t;

  vec_t vecs[5];
  exp_t sb[$];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " sig"}, 32'(sig_o), 0);
    check({tag, " stb"}, 32'(stb_o), 0);
    check({tag, " run"}, 32'(run_o), 0);
    check({tag, " err"}, 32'(err_o), 0);
    check({tag, " pcnt"}, 32'(pulse_cnt_o), 0);
    check({tag, " rdy"}, 32'(cfg_rdy_o), 1);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; en_i = 1'b0; cfg_vld_i = 1'b0; oe_i = 1'b1;
    period_i = '0; width_i = '0;
    step();
    check_reset_vals("reset");
    rst_ni = 1'b1;
  endtask

  task automatic load(input int p, input int w);
    period_i = TW'(p); width_i = TW'(w); cfg_vld_i = 1'b1;
    step();
    cfg_vld_i = 1'b0;
  endtask

  task automatic wait_stb();
    int n = 0;
    do begin
      step();
      n++;
    end while (stb_o !== 1'b1 && n < 200);
    if (stb_o !== 1'b1) check("wait_stb timeout", 0, 1);
  endtask

  // Starts on a strobe cycle, returns on the next strobe cycle.
  task automatic measure(output int hi, output int lo);
    int n = 0;
    hi = 0; lo = 0;
    while (sig_o === 1'b1 && n < 100) begin hi++; step(); n++; end
    while (stb_o !== 1'b1 && n < 100) begin lo++; step(); n++; end
  endtask

  task automatic start_run(input int p, input int w);
    do_reset();
    en_i = 1'b1;
    load(p, w);
    wait_stb();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hi, lo, n, cnt_sig, cnt_stb;
    logic [PW-1:0] pc0;
    exp_t e;

    vecs[0] = '{period: 10, width: 3, nper: 3,  exp_hi: 3, exp_lo: 7};
    vecs[1] = '{period: 2,  width: 1, nper: 20, exp_hi: 1, exp_lo: 1};
    vecs[2] = '{period: 5,  width: 4, nper: 3,  exp_hi: 4, exp_lo: 1};
    vecs[3] = '{period: 7,  width: 1, nper: 3,  exp_hi: 1, exp_lo: 6};
    vecs[4] = '{period: 3,  width: 2, nper: 3,  exp_hi: 2, exp_lo: 1};

    do_reset();
    en_i = 1'b1;
    n = 0;
    repeat (5) begin step(); if (run_o === 1'b1) n++; end
    check("no cfg stays idle", 32'(n), 0);

    foreach (vecs[v]) begin
      do_reset();
      en_i = 1'b1;
      period_i = TW'(vecs[v].period); width_i = TW'(vecs[v].width); cfg_vld_i = 1'b1;
      // Two idle samples: one for the shadow slot, one for promotion to active.
      repeat (2) sb.push_back('{sig: 1'b0, stb: 1'b0, run: 1'b0, pcnt: '0});
      for (int p = 0; p < vecs[v].nper; p++)
        for (int k = 0; k < vecs[v].exp_hi + vecs[v].exp_lo; k++)
          sb.push_back('{sig: (k < vecs[v].exp_hi), stb: (k == 0), run: 1'b1, pcnt: PW'(p + 1)});
      while (sb.size() > 0) begin
        step();
        cfg_vld_i = 1'b0;
        e = sb.pop_front();
        check($sformatf("v%0d sig", v), 32'(sig_o), 32'(e.sig));
        check($sformatf("v%0d stb", v), 32'(stb_o), 32'(e.stb));
        check($sformatf("v%0d run", v), 32'(run_o), 32'(e.run));
        check($sformatf("v%0d pcnt", v), 32'(pulse_cnt_o), 32'(e.pcnt));
      end
    end

    do_reset();
    load(5, 0);
    check("err w=0 idle", 32'(err_o), 1);
    check("err rdy", 32'(cfg_rdy_o), 1);
    load(8, 8);
    check("err w=p", 32'(err_o), 1);
    en_i = 1'b1;
    step(); step();
    check("err no active", 32'(run_o), 0);
    load(4, 1);
    check("err cleared", 32'(err_o), 0);

    start_run(10, 3);
    period_i = TW'(10); width_i = '0; cfg_vld_i = 1'b1;
    step();
    cfg_vld_i = 1'b0;
    check("run err set", 32'(err_o), 1);
    check("run err sig kept", 32'(sig_o), 1);
    wait_stb();
    measure(hi, lo);
    check("run err hi", 32'(hi), 3);
    check("run err lo", 32'(lo), 7);
    load(8, 8);
    check("run err sticky", 32'(err_o), 1);
    load(10, 3);
    check("run err clear", 32'(err_o), 0);
    check("run err pend", 32'(cfg_rdy_o), 0);

    start_run(10, 3);
    period_i = TW'(20); width_i = TW'(5); cfg_vld_i = 1'b1;
    step();
    cfg_vld_i = 1'b0;
    n = 0;
    repeat (9) begin if (cfg_rdy_o !== 1'b0) n++; step(); end
    check("reload rdy low", 32'(n), 0);
    check("reload stb", 32'(stb_o), 1);
    check("reload rdy back", 32'(cfg_rdy_o), 1);
    measure(hi, lo);
    check("reload hi", 32'(hi), 5);
    check("reload lo", 32'(lo), 15);

    start_run(10, 3);
    repeat (9) step();
    check("bound last low", 32'(run_o & ~sig_o), 1);
    period_i = TW'(6); width_i = TW'(2); cfg_vld_i = 1'b1;
    step();
    cfg_vld_i = 1'b0;
    check("bound stb", 32'(stb_o), 1);
    check("bound pend", 32'(cfg_rdy_o), 0);
    measure(hi, lo);
    check("bound old hi", 32'(hi), 3);
    check("bound old lo", 32'(lo), 7);
    measure(hi, lo);
    check("bound new hi", 32'(hi), 2);
    check("bound new lo", 32'(lo), 4);

    start_run(10, 3);
    n = 1;
    step();
    en_i = 1'b0;
    while (run_o === 1'b1 && n < 50) begin n++; step(); end
    check("en drop run cycles", 32'(n), 10);
    check("en drop sig", 32'(sig_o), 0);
    repeat (3) step();
    check("en drop idle", 32'(run_o), 0);

    start_run(10, 3);
    oe_i = 1'b0;
    #1;
    check("oe0 sig", 32'(sig_o), 0);
    pc0 = pulse_cnt_o;
    cnt_sig = 0; cnt_stb = 0;
    repeat (20) begin
      step();
      if (sig_o === 1'b1) cnt_sig++;
      if (stb_o === 1'b1) cnt_stb++;
    end
    check("oe0 sig count", 32'(cnt_sig), 0);
    check("oe0 stb count", 32'(cnt_stb), 2);
    check("oe0 pcnt", 32'(pulse_cnt_o), 32'(PW'(pc0 + PW'(2))));
    oe_i = 1'b1;
    #1;
    check("oe1 sig", 32'(sig_o), 1);

    start_run(10, 3);
    step();
    check("mid rst high", 32'(sig_o), 1);
    rst_ni = 1'b0;
    step();
    check_reset_vals("mid rst");
    rst_ni = 1'b1;
    n = 0;
    repeat (8) begin step(); if (run_o === 1'b1) n++; end
    check("mid rst no restart", 32'(n), 0);
    load(4, 1);
    wait_stb();
    measure(hi, lo);
    check("mid rst new hi", 32'(hi), 1);
    check("mid rst new lo", 32'(lo), 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_gen.md
PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 SHALL have parameter T_CNT_WIDTH, default 32, width of period/width/counter values in clk_i cycles.
REQ-002 SHALL have parameter PCNT_WIDTH, default 16, width of the emitted-pulse counter.
REQ-003 SHALL have port clk_i  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_ni  in  1  reset; one clock, reset is synchronous and active-low.
REQ-005 SHALL have port en_i  in  1  run request; level-sensitive.
REQ-006 SHALL have port period_i  in  T_CNT_WIDTH  requested pulse period, cycles.
REQ-007 SHALL have port width_i  in  T_CNT_WIDTH  requested high time, cycles.
REQ-008 SHALL have port cfg_vld_i  in  1  config offer; sampled with period_i/width_i.
REQ-009 SHALL have port cfg_rdy_o  out  1  shadow config slot free.
REQ-010 SHALL have port oe_i  in  1  output enable for sig_o.
REQ-011 SHALL have port sig_o  out  1  generated periodic pulse train.
REQ-012 SHALL have port stb_o  out  1  one-cycle strobe marking first high cycle of each pulse.
REQ-013 SHALL have port run_o  out  1  generator active (not IDLE).
REQ-014 SHALL have port err_o  out  1  sticky invalid-config flag.
REQ-015 SHALL have port pulse_cnt_o  out  PCNT_WIDTH  pulses emitted since reset, wrapping.

Function
REQ-016 Config transfer SHALL occur on a clock edge with cfg_vld_i=1 and cfg_rdy_o=1; otherwise inputs ignored.
REQ-017 Config SHALL be valid iff period_i>=2, width_i>=1, width_i<period_i; valid config goes to shadow register, shadow marked pending.
REQ-018 Invalid transfer SHALL discard the config, leave active/shadow unchanged, set err_o the next cycle; err_o clears only on next valid transfer or reset.
REQ-019 cfg_rdy_o SHALL be 1 when shadow not pending; 0 while pending.
REQ-020 Shadow SHALL move to active config: in IDLE on the cycle after transfer; in run at the last LOW cycle of the current period (new values govern the next pulse); pending then clears.
REQ-021 FSM SHALL have states IDLE, HIGH, LOW; run_o=1 in HIGH and LOW.
REQ-022 IDLE->HIGH SHALL occur when en_i=1 and an active config exists; sig level rises the cycle after the edge that sees en_i=1 (1-cycle latency).
REQ-023 HIGH SHALL last exactly width cycles then LOW; LOW SHALL last exactly period-width cycles; period = exactly period cycles.
REQ-024 At end of LOW: en_i=1 -> HIGH (new pulse); en_i=0 -> IDLE; deassertion of en_i mid-period SHALL NOT truncate the period.
REQ-025 stb_o SHALL be 1 only in the first HIGH cycle of each pulse; pulse_cnt_o SHALL increment by 1 in that same cycle, wrapping from all-ones to 0.
REQ-026 sig_o SHALL equal registered internal level AND oe_i (combinational gate); stb_o, pulse_cnt_o, FSM unaffected by oe_i.
REQ-027 Simultaneous transfer and last LOW cycle: the shadow being written SHALL NOT apply that boundary; it applies at the following boundary.
REQ-028 Counters SHALL be T_CNT_WIDTH wide with no overflow possible for any valid config.

Reset
REQ-029 With rst_ni=0 at a clock edge: state IDLE, sig_o=0, stb_o=0, run_o=0, err_o=0, pulse_cnt_o=0, no active config, shadow not pending.
REQ-030 After reset cfg_rdy_o=1; en_i=1 without any valid config SHALL leave FSM in IDLE.
REQ-031 Reset asserted mid-pulse SHALL drop sig_o to 0 the cycle after the edge and discard active and shadow configs.

Verification
REQ-032 period=10,width=3,en_i=1,oe_i=1 -> sig_o high 3 / low 7 cycles, stb_o every 10 cycles, pulse_cnt_o 1,2,3...
REQ-033 period=2,width=1 -> sig_o toggles each cycle; period=5,width=4 -> 4 high /1 low.
REQ-034 width=0, or width=period=8 -> err_o=1, waveform unchanged; then valid config -> err_o=0.
REQ-035 running 10/3, load 20/5 mid-HIGH -> cfg_rdy_o=0 until period boundary, next pulse 5 high /15 low.
REQ-036 en_i dropped in 2nd HIGH cycle of 10/3 -> period completes (10 cycles total), run_o=0 after; oe_i=0 -> sig_o=0 but stb_o continues.
REQ-037 rst_ni=0 one cycle mid-HIGH -> all outputs at reset values, en_i=1 alone restarts nothing until new config.
